f1_sequencer: RTL and testbench

Start-light sequencer that consumes the pseudo-random byte from the design's `lfsr` and drives the 8-lamp F1 start gantry. On a trigger it lights lamps one per `tick`, holds all lamps on for a random number of ticks taken from the LFSR, then extinguishes them and pulses `done`. It sits directly downstream of `lfsr` (driving its `en`) and of the clock-tick divider that produces `tick`.

---
 rtl/f1_pkg.sv | 13 +
 rtl/delay_counter.sv | 28 ++
 rtl/f1_sequencer.sv | 79 +++++++
 tb/tb_f1_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and defaults for the F1 start-light sequencer
package f1_pkg;

    localparam int F1_NUM_LIGHTS = 8;
    localparam int F1_RND_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LIGHTS = 2'd1,
        HOLD   = 2'd2
    } f1_state_t;

endpackage

// File: rtl/delay_counter.sv
// rtl/delay_counter.sv - loadable down-counter that flags the final count
module delay_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero_next
);

    logic [WIDTH-1:0] count;

    // Load wins over decrement; a decrement at zero is dropped so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero_next = (count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/f1_sequencer.sv
// rtl/f1_sequencer.sv - F1 start gantry: lamps on one per tick, random hold, then out
module f1_sequencer
    import f1_pkg::*;
#(
    parameter int NUM_LIGHTS = F1_NUM_LIGHTS,
    parameter int RND_WIDTH  = F1_RND_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic                  tick,
    input  logic [RND_WIDTH-1:0]  rnd,
    output logic                  rnd_en,
    output logic [NUM_LIGHTS-1:0] data_out,
    output logic                  busy,
    output logic                  done
);

    f1_state_t            state;
    logic                 hold_load;
    logic                 hold_dec;
    logic                 hold_last;
    logic [RND_WIDTH-1:0] hold_val;

    // Lamps fill as a thermometer, so the next-to-last bit marks the tick that completes the row.
    assign hold_load = (state == LIGHTS) && tick && data_out[NUM_LIGHTS-2];
    assign hold_dec  = (state == HOLD) && tick && !hold_last;
    assign hold_val  = (rnd == '0) ? {{(RND_WIDTH-1){1'b0}}, 1'b1} : rnd;
    assign busy      = (state != IDLE);

    delay_counter #(
        .WIDTH(RND_WIDTH)
    ) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (hold_val),
        .dec      (hold_dec),
        .zero_next(hold_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_out <= '0;
            done     <= 1'b0;
            rnd_en   <= 1'b0;
        end else begin
            done   <= 1'b0;
            rnd_en <= hold_load;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= LIGHTS;
                    end
                end
                LIGHTS: begin
                    if (tick) begin
                        data_out <= {data_out[NUM_LIGHTS-2:0], 1'b1};
                        if (data_out[NUM_LIGHTS-2]) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick && hold_last) begin
                        data_out <= '0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_sequencer.sv
// tb/tb_f1_sequencer.sv - scoreboard bench for f1_sequencer
module tb_f1_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger;
    logic       tick;
    logic [7:0] rnd;
    logic       rnd_en;
    logic [7:0] data_out;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] d;
        logic       dn;
        logic       re;
    } ev_t;

    ev_t        sb[$];
    ev_t        ev;
    logic [7:0] prev_d;
    logic       prev_done;
    bit         mon_on   = 0;
    bit         trig_hold = 0;

    f1_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .tick    (tick),
        .rnd     (rnd),
        .rnd_en  (rnd_en),
        .data_out(data_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every lamp change or done pulse must match the next queued event.
    always @(negedge clk) begin
        if (mon_on) begin
            if ((data_out !== prev_d) || (done !== 1'b0)) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", {data_out, done}, {prev_d, 1'b0});
                end else begin
                    ev = sb.pop_front();
                    check("ev_data", data_out, ev.d);
                    check("ev_done", done, ev.dn);
                    check("ev_rnd_en", rnd_en, ev.re);
                end
            end else begin
                check("quiet_rnd_en", rnd_en, 0);
            end
            if (prev_done) check("done_width", done, 0);
            prev_d    = data_out;
            prev_done = done;
        end
    end

    task automatic step(input bit tg, input bit tk);
        trigger = tg;
        tick    = tk;
        @(posedge clk);
        #1;
        tick    = 1'b0;
        trigger = trig_hold;
    endtask

    task automatic push_lights(input bit with_done);
        for (int i = 1; i <= 8; i++) begin
            sb.push_back('{d: 8'((9'd1 << i) - 9'd1), dn: 1'b0, re: (i == 8)});
        end
        if (with_done) sb.push_back('{d: 8'h00, dn: 1'b1, re: 1'b0});
    endtask

    task automatic run_seq(input logic [7:0] r, input int gap, input bit poke, input bit tt);
        int hold;
        hold = (r == 8'h00) ? 1 : int'(r);
        rnd = r;
        push_lights(1'b1);
        step(1'b1, tt);
        check("busy_start", busy, 1);
        check("lamps_dark", data_out, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            repeat (gap - 1) step(poke, 1'b0);
        end
        rnd = 8'($urandom);
        for (int h = 1; h < hold; h++) begin
            step(1'b0, 1'b1);
            repeat (gap - 1) step(poke, 1'b0);
        end
        check("hold_ff", data_out, 8'hFF);
        check("hold_busy", busy, 1);
        step(1'b0, 1'b1);
        check("end_dark", data_out, 8'h00);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; trigger = 1'b0; tick = 1'b0; rnd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_out, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rnd_en", rnd_en, 0);
        rst = 1'b0;
        prev_d = 8'h00; prev_done = 1'b0; mon_on = 1;

        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom));
            check("idle_data", data_out, 8'h00);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
        end

        run_seq(8'h03, 4, 1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("done_clear", done, 0);
        run_seq(8'h00, 2, 1'b0, 1'b0);
        run_seq(8'hFF, 1, 1'b0, 1'b0);
        run_seq(8'h05, 3, 1'b1, 1'b0);
        run_seq(8'h02, 2, 1'b0, 1'b1);

        // Reset in the middle of the hold: lamps drop with no done pulse.
        rnd = 8'h05;
        push_lights(1'b0);
        sb.push_back('{d: 8'h00, dn: 1'b0, re: 1'b0});
        step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        check("pre_rst_ff", data_out, 8'hFF);
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        step(1'b0, 1'b0);
        run_seq(8'h04, 2, 1'b0, 1'b0);

        // Trigger held high: each run restarts right after the done cycle.
        trig_hold = 1;
        step(1'b0, 1'b0);
        run_seq(8'h02, 2, 1'b1, 1'b0);
        run_seq(8'h03, 2, 1'b1, 1'b0);
        trig_hold = 0;
        trigger   = 1'b0;
        run_seq(8'h01, 2, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
